// File: rtl/mdu_defs.sv
// Shared definitions for the EX-stage multiply/divide unit: FSM state encoding and default sizes.
package mdu_defs;

  localparam int MDU_WIDTH     = 32;
  localparam int MDU_DIV_ITERS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/div_radix2_core.sv
// One restoring radix-2 division step: shifts the next dividend bit into the partial remainder,
// subtracts the divisor when it fits and shifts the resulting quotient bit in at the bottom.
module div_radix2_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits; after a successful subtract it always fits in WIDTH.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;
  assign o_rem   = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quo   = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage; busy_o stalls the pipeline while an op is in flight.
// Define DIV_BY_ZERO_FAST_EN to finish a divide by zero in one cycle with lo=all ones, hi=raw dividend.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] srca_i,
  input  logic [WIDTH-1:0] srcb_i,
  input  logic             cancel_i,
  input  logic             ext_stall_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e r_state, w_next_state;

  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_rem;
  logic               r_sa;
  logic               r_sb;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_start;
  logic               w_fast_zero;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_core_rem;
  logic [WIDTH-1:0]   w_core_quo;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic               w_last_iter;

  assign w_start = (mul_i | div_i) & ~cancel_i & ~rst;

`ifdef DIV_BY_ZERO_FAST_EN
  assign w_fast_zero = (srcb_i == '0);
`else
  assign w_fast_zero = 1'b0;
`endif

  // Magnitudes are unsigned, so the most negative input becomes exactly 2**(WIDTH-1).
  assign w_sa    = signed_i & srca_i[WIDTH-1];
  assign w_sb    = signed_i & srcb_i[WIDTH-1];
  assign w_abs_a = w_sa ? (~srca_i + 1'b1) : srca_i;
  assign w_abs_b = w_sb ? (~srcb_i + 1'b1) : srcb_i;

  div_radix2_core #(.WIDTH(WIDTH)) u_div_core (
    .i_rem     (r_rem),
    .i_quo     (r_opa),
    .i_divisor (r_opb),
    .o_rem     (w_core_rem),
    .o_quo     (w_core_quo)
  );

  assign w_last_iter = (r_cnt == CNT_W'(WIDTH-1));
  assign w_quo_fix   = (r_sa ^ r_sb) ? (~w_core_quo + 1'b1) : w_core_quo;
  assign w_rem_fix   = r_sa ? (~w_core_rem + 1'b1) : w_core_rem;
  assign w_prod      = {{WIDTH{1'b0}}, r_opa} * {{WIDTH{1'b0}}, r_opb};
  assign w_prod_fix  = (r_sa ^ r_sb) ? (~w_prod + 1'b1) : w_prod;

  always_comb begin
    w_next_state = r_state;
    busy_o       = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          busy_o = 1'b1;
          if (div_i) w_next_state = w_fast_zero ? ST_DONE : ST_DIV;
          else       w_next_state = ST_MUL;
        end
      end
      ST_MUL: begin
        busy_o       = 1'b1;
        w_next_state = ST_DONE;
      end
      ST_DIV: begin
        busy_o = 1'b1;
        if (w_last_iter) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        valid_o = 1'b1;
        if (!ext_stall_i) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (cancel_i) begin
      w_next_state = ST_IDLE;
      busy_o       = 1'b0;
      valid_o      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_rem   <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_opa <= w_abs_a;
            r_opb <= w_abs_b;
            r_sa  <= w_sa;
            r_sb  <= w_sb;
            r_rem <= '0;
            r_cnt <= '0;
            if (div_i && w_fast_zero) begin
              r_hi <= srca_i;
              r_lo <= '1;
            end
          end
        end
        ST_MUL: begin
          if (!cancel_i) {r_hi, r_lo} <= w_prod_fix;
        end
        ST_DIV: begin
          r_rem <= w_core_rem;
          r_opa <= w_core_quo;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_iter && !cancel_i) begin
            r_hi <= w_rem_fix;
            r_lo <= w_quo_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: latency-based behavioural model with plain-arithmetic results,
// directed corner cases and randomized MULT/DIV traffic with cancels and external stalls.
`timescale 1ns/1ps
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mul_i, div_i, signed_i, cancel_i, ext_stall_i;
  logic [31:0] srca_i, srcb_i;
  logic        busy_o, valid_o;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .mul_i       (mul_i),
    .div_i       (div_i),
    .signed_i    (signed_i),
    .srca_i      (srca_i),
    .srcb_i      (srcb_i),
    .cancel_i    (cancel_i),
    .ext_stall_i (ext_stall_i),
    .busy_o      (busy_o),
    .valid_o     (valid_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  logic        checkEn    = 1'b0;
  logic        expBusy, expValid;
  logic [31:0] expHi, expLo;
  logic [31:0] lastHi, lastLo;

  logic        rIsDiv, rSgn, rBoth;
  logic [31:0] rA, rB;
  int          rStall, rCancel, rLat;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] modelResult(input logic isDiv, input logic sgn,
                                              input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    if (!isDiv) begin
      if (sgn) return 64'(sa * sb);
      return {32'd0, a} * {32'd0, b};
    end
    if (b == 32'd0) begin
`ifdef DIV_BY_ZERO_FAST_EN
      return {a, 32'hFFFF_FFFF};
`else
      return {a, (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF};
`endif
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic int latencyOf(input logic isDiv, input logic [31:0] b);
    if (!isDiv) return 2;
`ifdef DIV_BY_ZERO_FAST_EN
    if (b == 32'd0) return 1;
`endif
    return 33;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("busy_o",  64'(busy_o),  64'(expBusy));
      checkOutput("valid_o", 64'(valid_o), 64'(expValid));
      checkOutput("hi_o",    64'(hi_o),    64'(expHi));
      checkOutput("lo_o",    64'(lo_o),    64'(expLo));
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      mul_i       = 1'b0;
      div_i       = 1'b0;
      signed_i    = 1'($urandom_range(0, 1));
      srca_i      = $urandom;
      srcb_i      = $urandom;
      cancel_i    = 1'($urandom_range(0, 1));
      ext_stall_i = 1'($urandom_range(0, 1));
      expBusy     = 1'b0;
      expValid    = 1'b0;
      expHi       = lastHi;
      expLo       = lastLo;
      stepCycle();
    end
  endtask

  // Holds the instruction in EX until it retires (DONE released) or is cancelled.
  task automatic applyStimulus(input logic isDiv, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                               input int stallN, input int cancelAt, input logic both);
    logic [63:0] res;
    int          lat;
    res = modelResult(isDiv, sgn, a, b);
    lat = latencyOf(isDiv, b);
    for (int k = 0; k <= lat + stallN; k++) begin
      mul_i    = ~isDiv | both;
      div_i    = isDiv;
      signed_i = sgn;
      srca_i   = a;
      srcb_i   = b;
      cancel_i = (k == cancelAt);
      if (k < lat) ext_stall_i = 1'($urandom_range(0, 1));
      else         ext_stall_i = (k < lat + stallN);
      if (k == cancelAt) begin
        expBusy  = 1'b0;
        expValid = 1'b0;
        expHi    = lastHi;
        expLo    = lastLo;
        stepCycle();
        break;
      end else if (k < lat) begin
        expBusy  = 1'b1;
        expValid = 1'b0;
        expHi    = lastHi;
        expLo    = lastLo;
      end else begin
        expBusy  = 1'b0;
        expValid = 1'b1;
        expHi    = res[63:32];
        expLo    = res[31:0];
      end
      stepCycle();
      if (k == lat + stallN) begin
        lastHi = res[63:32];
        lastLo = res[31:0];
      end
    end
    idleCycles(1 + $urandom_range(0, 2));
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'($urandom_range(0, 20));
      1:       v = -32'($urandom_range(1, 20));
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1;
    mul_i = 1'b0; div_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0; ext_stall_i = 1'b0;
    srca_i = '0; srcb_i = '0;
    lastHi = '0; lastLo = '0;
    expBusy = 1'b0; expValid = 1'b0; expHi = '0; expLo = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy_o",  64'(busy_o),  64'd0);
    checkOutput("reset valid_o", 64'(valid_o), 64'd0);
    checkOutput("reset hi_o",    64'(hi_o),    64'd0);
    checkOutput("reset lo_o",    64'(lo_o),    64'd0);
    rst = 1'b0;

    checkOutput("model MULTU", modelResult(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2), 64'h0000_0001_FFFF_FFFE);
    checkOutput("model MULT",  modelResult(1'b0, 1'b1, -32'd3, 32'd5),        64'hFFFF_FFFF_FFFF_FFF1);
    checkOutput("model DIV",   modelResult(1'b1, 1'b1, -32'd7, 32'd2),        64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("model DIVU",  modelResult(1'b1, 1'b0, 32'd100, 32'd7),       64'h0000_0002_0000_000E);
    checkOutput("model DIVU0", modelResult(1'b1, 1'b0, 32'd5, 32'd0),         64'h0000_0005_FFFF_FFFF);

    checkEn = 1'b1;
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 0, -1, 1'b0);
    applyStimulus(1'b0, 1'b1, -32'd3, 32'd5, 0, -1, 1'b0);
    applyStimulus(1'b1, 1'b1, -32'd7, 32'd2, 0, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 0, 10, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 0, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd9, 32'd3, 4, -1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd0, 0, -1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1, 1'b1);
    applyStimulus(1'b1, 1'b1, -32'd9, 32'd0, 0, -1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 2, -1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'd6, 32'd7, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rIsDiv  = 1'($urandom_range(0, 1));
      rSgn    = 1'($urandom_range(0, 1));
      rBoth   = rIsDiv & ($urandom_range(0, 5) == 0);
      rA      = pickOperand();
      rB      = ($urandom_range(0, 9) == 0) ? 32'd0 : pickOperand();
      rStall  = $urandom_range(0, 3);
      rLat    = latencyOf(rIsDiv, rB);
      rCancel = ($urandom_range(0, 4) == 0) ? $urandom_range(0, rLat - 1) : -1;
      applyStimulus(rIsDiv, rSgn, rA, rB, rStall, rCancel, rBoth);
    end

    // Asynchronous reset partway through a divide must clear everything without waiting for a clock.
    for (int k = 0; k < 15; k++) begin
      mul_i = 1'b0; div_i = 1'b1; signed_i = 1'b0; srca_i = 32'd1000; srcb_i = 32'd3;
      cancel_i = 1'b0; ext_stall_i = 1'b0;
      expBusy = 1'b1; expValid = 1'b0; expHi = lastHi; expLo = lastLo;
      stepCycle();
    end
    #2;
    checkEn = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("async rst busy_o",  64'(busy_o),  64'd0);
    checkOutput("async rst valid_o", 64'(valid_o), 64'd0);
    checkOutput("async rst hi_o",    64'(hi_o),    64'd0);
    checkOutput("async rst lo_o",    64'(lo_o),    64'd0);
    div_i = 1'b0;
    stepCycle();
    rst = 1'b0;
    lastHi = '0;
    lastLo = '0;
    expBusy = 1'b0; expValid = 1'b0; expHi = '0; expLo = '0;
    checkEn = 1'b1;
    idleCycles(3);
    applyStimulus(1'b1, 1'b0, 32'd100, 32'd7, 0, -1, 1'b0);
    checkEn = 1'b0;

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
